// File: rtl/if_stage_ctrl.sv
// Fetch control: PC, IF/ID register, imem handshake.
// Optional IF_STAT_EN adds stall/flush counters.
module if_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        Stall_i,
  input  logic        PCWrite_i,
  input  logic        NoOp_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o,
  output logic        idex_noop_o
`ifdef IF_STAT_EN
  ,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        noop_q;
  logic        xfer;
  logic [31:0] pc_inc;

  assign xfer   = req_q & imem_ready_i;
  assign pc_inc = pc_q + 32'd4;

  // Next-state: flush first, then per-state fetch rules
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_d       = skid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (state_q != IDLE && flush_i) begin
      pc_d         = branch_target_i;
      skid_d       = NOP_INSTR;
      ifid_pc_d    = pc_q;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      state_d      = (req_q && !xfer) ? DRAIN : FETCH;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) state_d = FETCH;
        end
        FETCH: begin
          if (xfer && Stall_i) begin
            skid_d  = imem_data_i;
            state_d = HOLD;
          end else if (xfer) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_data_i;
            ifid_valid_d = 1'b1;
            if (PCWrite_i) pc_d = pc_inc;
          end else if (!Stall_i) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!Stall_i) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = skid_q;
            ifid_valid_d = 1'b1;
            skid_d       = NOP_INSTR;
            if (PCWrite_i) pc_d = pc_inc;
            state_d = FETCH;
          end
        end
        DRAIN: begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          if (xfer) state_d = FETCH;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Request is registered; a drained request keeps its old address
  always_comb begin
    req_d  = (state_d == FETCH) || (state_d == DRAIN);
    addr_d = (state_d == DRAIN) ? addr_q : pc_d;
  end

  // All fetch-side state, synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      skid_q       <= NOP_INSTR;
      addr_q       <= RESET_PC;
      req_q        <= 1'b0;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      noop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_q       <= skid_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      noop_q       <= NoOp_i | flush_i;
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_valid_o = ifid_valid_q;
  assign idex_noop_o  = noop_q;

`ifdef IF_STAT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Saturating event counters
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (state_q != IDLE && Stall_i && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_i && flush_cnt_q != 32'hFFFF_FFFF)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_count_o  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Bench for if_stage_ctrl: directed + random
// stimulus against a request/skid reference model.
module tb_if_stage_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        Stall_i = 1'b0;
  logic        PCWrite_i = 1'b1;
  logic        NoOp_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i = 1'b0;
  logic [31:0] imem_data_i;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_instr_o;
  logic        ifid_valid_o;
  logic        idex_noop_o;

  int n_chk = 0;
  int n_fail = 0;

  if_stage_ctrl #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .start_i(start_i),
    .Stall_i(Stall_i),
    .PCWrite_i(PCWrite_i),
    .NoOp_i(NoOp_i),
    .flush_i(flush_i),
    .branch_target_i(branch_target_i),
    .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i),
    .imem_data_i(imem_data_i),
    .ifid_pc_o(ifid_pc_o),
    .ifid_instr_o(ifid_instr_o),
    .ifid_valid_o(ifid_valid_o),
    .idex_noop_o(idex_noop_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign imem_data_i = word(imem_addr_o);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: a request is open whenever running and no word is
  // parked; a discarded request keeps its address until it returns.
  bit          m_run, m_out, m_disc, m_full;
  bit          e_valid, e_noop;
  logic [31:0] m_pc, m_oaddr, m_skid;
  logic [31:0] e_pc, e_instr;

  task automatic model_reset();
    m_run = 0; m_out = 0; m_disc = 0; m_full = 0;
    m_pc = RPC; m_oaddr = RPC; m_skid = NOP;
    e_pc = 32'h0; e_instr = NOP; e_valid = 0; e_noop = 0;
  endtask

  task automatic bubble();
    e_pc = m_pc; e_instr = NOP; e_valid = 0;
  endtask

  task automatic model_step();
    bit done;
    if (!rst_i) begin
      model_reset();
      return;
    end
    e_noop = NoOp_i | flush_i;
    if (!m_run) begin
      if (start_i) begin
        m_run = 1; m_out = 1; m_oaddr = m_pc;
      end
      return;
    end
    done = m_out && imem_ready_i;
    if (flush_i) begin
      bubble();
      m_pc = branch_target_i;
      m_full = 0;
      m_disc = m_out && !done;
    end else if (m_disc) begin
      bubble();
      if (done) m_disc = 0;
    end else if (m_full) begin
      if (!Stall_i) begin
        e_pc = m_pc; e_instr = m_skid; e_valid = 1;
        m_full = 0;
        if (PCWrite_i) m_pc = m_pc + 32'd4;
      end
    end else if (done) begin
      if (Stall_i) begin
        m_skid = word(m_oaddr); m_full = 1;
      end else begin
        e_pc = m_pc; e_instr = word(m_oaddr); e_valid = 1;
        if (PCWrite_i) m_pc = m_pc + 32'd4;
      end
    end else if (!Stall_i) begin
      bubble();
    end
    m_out = !m_full;
    if (!m_disc) m_oaddr = m_pc;
  endtask

  initial model_reset();

  // Per-cycle comparison against the model
  always @(posedge clk_i) begin
    model_step();
    #1;
    chk("req", {31'b0, imem_req_o}, {31'b0, m_out});
    chk("addr", imem_addr_o, m_oaddr);
    chk("valid", {31'b0, ifid_valid_o}, {31'b0, e_valid});
    chk("instr", ifid_instr_o, e_instr);
    chk("noop", {31'b0, idex_noop_o}, {31'b0, e_noop});
    if (e_valid) chk("ifid_pc", ifid_pc_o, e_pc);
  end

  task automatic tick();
    @(negedge clk_i);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_req", {31'b0, imem_req_o}, 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", {31'b0, ifid_valid_o}, 32'h0);
    chk("rst_instr", ifid_instr_o, 32'h13);
    chk("rst_pc", ifid_pc_o, 32'h0);
    chk("rst_noop", {31'b0, idex_noop_o}, 32'h0);

    // zero-wait streaming
    rst_i = 1; start_i = 1; imem_ready_i = 1; PCWrite_i = 1;
    repeat (4) tick();
    chk("zw_pc", ifid_pc_o, 32'h8);
    chk("zw_instr", ifid_instr_o, word(32'h8));
    chk("zw_valid", {31'b0, ifid_valid_o}, 32'h1);
    chk("zw_addr", imem_addr_o, 32'hC);

    // stall two cycles with a completing fetch
    Stall_i = 1;
    tick();
    chk("st_req", {31'b0, imem_req_o}, 32'h0);
    chk("st_pc", ifid_pc_o, 32'h8);
    tick();
    Stall_i = 0;
    tick();
    chk("st_rel_pc", ifid_pc_o, 32'hC);
    chk("st_rel_ins", ifid_instr_o, word(32'hC));
    chk("st_rel_addr", imem_addr_o, 32'h10);

    // three wait states
    imem_ready_i = 0;
    repeat (3) begin
      tick();
      chk("ws_valid", {31'b0, ifid_valid_o}, 32'h0);
      chk("ws_instr", ifid_instr_o, 32'h13);
      chk("ws_addr", imem_addr_o, 32'h10);
    end
    imem_ready_i = 1;
    tick();
    chk("ws_pc", ifid_pc_o, 32'h10);
    chk("ws_data", ifid_instr_o, word(32'h10));

    // flush while the fetch of 0x14 is outstanding
    imem_ready_i = 0; flush_i = 1; branch_target_i = 32'h40;
    tick();
    chk("fl_req", {31'b0, imem_req_o}, 32'h1);
    chk("fl_addr", imem_addr_o, 32'h14);
    chk("fl_noop", {31'b0, idex_noop_o}, 32'h1);
    flush_i = 0;
    tick();
    chk("dr_noop", {31'b0, idex_noop_o}, 32'h0);
    chk("dr_addr", imem_addr_o, 32'h14);
    imem_ready_i = 1;
    tick();
    chk("dr_new", imem_addr_o, 32'h40);
    chk("dr_valid", {31'b0, ifid_valid_o}, 32'h0);
    tick();
    chk("dr_pc", ifid_pc_o, 32'h40);
    chk("dr_ins", ifid_instr_o, word(32'h40));

    // flush together with stall out of HOLD
    Stall_i = 1;
    tick();
    chk("fs_hold", {31'b0, imem_req_o}, 32'h0);
    flush_i = 1; branch_target_i = 32'h80;
    tick();
    chk("fs_addr", imem_addr_o, 32'h80);
    chk("fs_req", {31'b0, imem_req_o}, 32'h1);
    chk("fs_valid", {31'b0, ifid_valid_o}, 32'h0);
    flush_i = 0; Stall_i = 0;
    tick();
    chk("fs_pc", ifid_pc_o, 32'h80);
    chk("fs_ins", ifid_instr_o, word(32'h80));

    // PC wrap
    flush_i = 1; branch_target_i = 32'hFFFF_FFFC;
    tick();
    flush_i = 0;
    tick();
    chk("wr_pc", ifid_pc_o, 32'hFFFF_FFFC);
    chk("wr_addr", imem_addr_o, 32'h0);

    // PCWrite low re-fetches the same pc
    PCWrite_i = 0;
    tick();
    chk("pw_pc", ifid_pc_o, 32'h0);
    chk("pw_addr", imem_addr_o, 32'h0);
    PCWrite_i = 1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_i        = ($urandom_range(199) != 0);
      start_i      = ($urandom_range(99) < 80);
      Stall_i      = ($urandom_range(99) < 30);
      PCWrite_i    = ($urandom_range(99) < 85);
      NoOp_i       = ($urandom_range(99) < 20);
      flush_i      = ($urandom_range(99) < 10);
      imem_ready_i = ($urandom_range(99) < 60);
      if ($urandom_range(7) == 0)
        branch_target_i = 32'hFFFF_FFF8;
      else
        branch_target_i = {$urandom(), 2'b00} >> 0;
      tick();
    end

    // reset while in HOLD
    rst_i = 1; start_i = 1; Stall_i = 0; flush_i = 0;
    NoOp_i = 0; PCWrite_i = 1; imem_ready_i = 1;
    repeat (3) tick();
    Stall_i = 1;
    tick();
    chk("hr_hold", {31'b0, imem_req_o}, 32'h0);
    rst_i = 0;
    tick();
    chk("hr_req", {31'b0, imem_req_o}, 32'h0);
    chk("hr_valid", {31'b0, ifid_valid_o}, 32'h0);
    chk("hr_addr", imem_addr_o, 32'h0);
    rst_i = 1; start_i = 0; Stall_i = 0;
    tick();
    chk("hr_idle", {31'b0, imem_req_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage_ctrl.md
Name: if_stage_ctrl

Overview:
- Fetch-side responder to the load-use hazard interface.
- Owns the PC register, the IF/ID pipeline register and the instruction-memory request handshake.
- Obeys Stall/PCWrite/NoOp requests from hazard detection and branch flushes from EX.
- Sits between instruction memory and the ID stage; supplies ID with a valid instruction or a NOP bubble every cycle.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, encoding written into IF/ID for a bubble (addi x0,x0,0).

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- start_i  in  1  leaves IDLE when high; level, sampled each cycle.
- Stall_i  in  1  hold IF/ID contents.
- PCWrite_i  in  1  0 = hold PC.
- NoOp_i  in  1  zero the ID/EX control field this cycle.
- flush_i  in  1  branch taken in EX.
- branch_target_i  in  32  new PC when flush_i is high.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address.
- imem_ready_i  in  1  response valid; completes the request.
- imem_data_i  in  32  fetched word, valid with imem_ready_i.
- ifid_pc_o  out  32  PC of the instruction in IF/ID.
- ifid_instr_o  out  32  instruction in IF/ID.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- idex_noop_o  out  1  registered bubble command to ID/EX control.

Behaviour:
- Reset (rst_i==0 at posedge):
  - pc=RESET_PC, state=IDLE, skid buffer empty.
  - ifid_pc_o=0, ifid_instr_o=NOP_INSTR, ifid_valid_o=0, idex_noop_o=0.
  - imem_req_o=0, imem_addr_o=RESET_PC.
  - Reset mid-fetch abandons the request; imem_req_o drops the next cycle.
- States: IDLE, FETCH, HOLD, DRAIN.
- Handshake rules:
  - imem_req_o=1 in FETCH and DRAIN, else 0.
  - imem_addr_o constant while the request is outstanding.
  - A transfer completes on a cycle with req && ready.
  - imem_ready_i with req low is ignored.
- IDLE: go to FETCH when start_i=1.
- FETCH, transfer completes:
  - No Stall_i and no flush_i: IF/ID <= {pc, imem_data_i, valid=1}; pc += 4 if PCWrite_i; stay in FETCH. One fetch per cycle when memory is zero-wait.
  - Stall_i=1: IF/ID held; word captured into the skid buffer; pc held; go to HOLD.
- FETCH, no completion:
  - If not Stall_i: IF/ID <= bubble {pc, NOP_INSTR, valid=0}.
  - If Stall_i: IF/ID held.
- HOLD:
  - imem_req_o=0.
  - When Stall_i drops: IF/ID <= skid word with valid=1, pc += 4 if PCWrite_i, skid emptied, go to FETCH.
- flush_i (highest priority, any non-IDLE state):
  - pc <= branch_target_i; IF/ID <= bubble; skid emptied.
  - If a request is outstanding and incomplete that cycle, go to DRAIN; otherwise go to FETCH.
  - Stall_i and PCWrite_i are ignored in the flush cycle.
- DRAIN:
  - Keeps the old address and request until ready.
  - Discards the returned data; IF/ID stays a bubble.
  - Then go to FETCH at the new pc.
  - A further flush in DRAIN only updates pc.
- PC arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- idex_noop_o <= NoOp_i | flush_i (one-cycle latency).
- PCWrite_i=0 with Stall_i=0 is legal: IF/ID advances with a re-fetch of the same pc.

Optional Feature:
- IF_STAT_EN defined: adds outputs stall_cycles_o[31:0] and flush_count_o[31:0].
  - stall_cycles_o: increments each non-IDLE cycle with Stall_i=1.
  - flush_count_o: increments each flush_i cycle.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Zero-wait memory (ready tied high), start_i=1 -> fetch addresses 0,4,8,...; ifid_pc_o trails imem_addr_o by 1 cycle; ifid_valid_o=1 from cycle 2.
- Stall_i=1 for 2 cycles at pc=8 with a completing fetch -> IF/ID holds pc 4; state HOLD, imem_req_o=0; after release IF/ID={8, word@8}; next address 12; no re-fetch of 8.
- 3-wait-state memory -> IF/ID shows NOP_INSTR, valid=0, for 3 cycles; imem_addr_o stable through the wait; data then lands in IF/ID.
- flush_i with branch_target_i=0x40 while a fetch of 0x10 is outstanding (ready after 2 cycles) -> DRAIN; 0x10 data discarded; next request address 0x40; idex_noop_o=1 one cycle after the flush.
- flush_i and Stall_i together -> flush wins; pc=target; skid emptied; IF/ID bubble.
- rst_i=0 during HOLD -> next cycle: pc=RESET_PC, IDLE, ifid_valid_o=0, imem_req_o=0. With IF_STAT_EN: counters read 0.
